// File: rtl/huffman_decoder.sv
// huffman_decoder: bit-serial canonical Huffman decoder, one code bit per clock,
// fed by 16-bit words and driven by runtime-loaded count/symbol tables.
module huffman_decoder #(
   parameter int MAX_LEN = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] data_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        err,
   input  logic        flush,
   input  logic        cfg_we,
   input  logic        cfg_sel,
   input  logic [7:0]  cfg_addr,
   input  logic [7:0]  cfg_data
);
   localparam int W = MAX_LEN + 1;
   localparam logic [3:0] LMAX = 4'(MAX_LEN);
   localparam logic [7:0] AMAX = 8'(MAX_LEN);

   logic [7:0]   cnt [1:MAX_LEN];
   logic [7:0]   sym [256];
   logic [15:0]  shreg;
   logic [4:0]   bits_left;
   logic [W-1:0] code, first, c, diff;
   logic [8:0]   index;
   logic [3:0]   len;
   logic [7:0]   cl, sa;
   logic         consume, load, match;

   assign consume  = enable & ~err & (bits_left != 5'd0);
   assign in_ready = ~rst & enable & ~err & ~flush & ((bits_left == 5'd0) | ((bits_left == 5'd1) & consume));
   assign load     = in_valid & in_ready;
   assign c        = code | W'(shreg[15]);
   assign cl       = cnt[len];
   assign diff     = c - first;
   // a wrapped (negative) offset is huge and therefore never matches
   assign match    = diff < W'(cl);
   assign sa       = index[7:0] + diff[7:0];

   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 1; i <= MAX_LEN; i++) cnt[i] <= '0;
      else if (cfg_we & ~enable & ~cfg_sel & (cfg_addr != 8'd0) & (cfg_addr <= AMAX))
         cnt[cfg_addr[3:0]] <= cfg_data;

   always_ff @(posedge clk)
      if (cfg_we & ~enable & cfg_sel) sym[cfg_addr] <= cfg_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shreg      <= '0;
         bits_left  <= '0;
         code       <= '0;
         first      <= '0;
         index      <= '0;
         len        <= 4'd1;
         err        <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (flush) begin
            bits_left <= '0;
            code      <= '0;
            first     <= '0;
            index     <= '0;
            len       <= 4'd1;
            err       <= 1'b0;
         end else begin
            if (load) begin
               shreg     <= data_in;
               bits_left <= 5'd16;
            end else if (consume) begin
               shreg     <= {shreg[14:0], 1'b0};
               bits_left <= bits_left - 5'd1;
            end
            if (consume) begin
               if (match) begin
                  data_out   <= sym[sa];
                  data_valid <= 1'b1;
                  code       <= '0;
                  first      <= '0;
                  index      <= '0;
                  len        <= 4'd1;
               end else if (len == LMAX) begin
                  err <= 1'b1;
               end else begin
                  index <= index + 9'(cl);
                  first <= (first + W'(cl)) << 1;
                  code  <= c << 1;
                  len   <= len + 4'd1;
               end
            end
         end
      end
endmodule
